// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver:
//   - uart_state_e    : receiver FSM state encoding
//   - PRESCALE_W      : width of the prescale / edge-counter datapath
//   - PRESCALE_8/16/32: legal oversampling ratios
//   - PARITY_EVEN/ODD : Parity_type encodings
//   - expected_parity : parity bit a transmitter would append to a word
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   localparam int          PRESCALE_W  = 6;
   localparam logic [5:0]  PRESCALE_8  = 6'd8;
   localparam logic [5:0]  PRESCALE_16 = 6'd16;
   localparam logic [5:0]  PRESCALE_32 = 6'd32;

   localparam logic        PARITY_EVEN = 1'b0;
   localparam logic        PARITY_ODD  = 1'b1;

   // data_xor is the XOR-reduction of the received word. Even parity makes
   // the total number of ones even (bit = ^data); odd parity inverts it.
   function automatic logic expected_parity(input logic data_xor, input logic ptype);
      return data_xor ^ (ptype == PARITY_ODD);
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// Bit-period edge counter plus 3-sample majority voter.
// Ports:
//   CLK         in   oversampling clock
//   Reset       in   asynchronous, active-low reset
//   en_i        in   1 while the receiver is inside a frame (counter runs)
//   prescale_i  in   CLK cycles per bit (8, 16 or 32), held stable per frame
//   rx_i        in   synchronized serial line
//   last_edge_o out  1 on the last cycle of the current bit period
//   bit_o       out  majority of the three mid-bit samples of this period
// -----------------------------------------------------------------------------
module uart_rx_sampler
   import uart_pkg::*;
(
   input  logic                  CLK,
   input  logic                  Reset,
   input  logic                  en_i,
   input  logic [PRESCALE_W-1:0] prescale_i,
   input  logic                  rx_i,
   output logic                  last_edge_o,
   output logic                  bit_o
);

   logic [PRESCALE_W-1:0] cnt_q, cnt_d;
   logic [2:0]            smp_q, smp_d;
   logic [PRESCALE_W-1:0] half;

   assign half        = {1'b0, prescale_i[PRESCALE_W-1:1]};
   assign last_edge_o = en_i && (cnt_q == prescale_i - 6'd1);

   // Counter is held at 0 while idle so the first START cycle is count 0.
   always_comb begin
      cnt_d = '0;
      if (en_i) begin
         cnt_d = last_edge_o ? '0 : cnt_q + 6'd1;
      end
   end

   always_comb begin
      smp_d = smp_q;
      if (en_i) begin
         if (cnt_q == half - 6'd1) smp_d[0] = rx_i;
         if (cnt_q == half)        smp_d[1] = rx_i;
         if (cnt_q == half + 6'd1) smp_d[2] = rx_i;
      end
   end

   // All three samples are refreshed well before the last edge of each bit
   // for every legal prescale, so no stale sample leaks between bits.
   assign bit_o = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         cnt_q <= '0;
         smp_q <= 3'b111;
      end else begin
         cnt_q <= cnt_d;
         smp_q <= smp_d;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// Oversampling UART receiver: start bit, `width` data bits LSB first,
// optional parity bit, one stop bit.
// Ports:
//   CLK          in   oversampling clock
//   Reset        in   asynchronous, active-low reset
//   Rx_in        in   asynchronous serial line, idle high
//   Prescale     in   CLK cycles per bit (8, 16, 32), captured while idle
//   Parity_EN    in   1 = frame carries a parity bit, captured while idle
//   Parity_type  in   0 = even, 1 = odd, captured while idle
//   Data_out     out  last word received without error
//   Data_valid   out  one-cycle pulse when Data_out is updated
//   Parity_error out  one-cycle pulse on parity mismatch
//   Stop_error   out  one-cycle pulse when the stop bit samples low
// -----------------------------------------------------------------------------
module uart_rx
   import uart_pkg::*;
#(
   parameter int width = 8
) (
   input  logic                  CLK,
   input  logic                  Reset,
   input  logic                  Rx_in,
   input  logic [PRESCALE_W-1:0] Prescale,
   input  logic                  Parity_EN,
   input  logic                  Parity_type,
   output logic [width-1:0]      Data_out,
   output logic                  Data_valid,
   output logic                  Parity_error,
   output logic                  Stop_error
);

   localparam int BCNT_W = (width > 1) ? $clog2(width) : 1;

   uart_state_e           state_q, state_d;
   logic [1:0]            sync_q;
   logic                  rx_s;
   logic [BCNT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [width-1:0]      shift_q, shift_d;
   logic [width-1:0]      data_q, data_d;
   logic [PRESCALE_W-1:0] presc_q, presc_d;
   logic                  par_en_q, par_en_d;
   logic                  par_type_q, par_type_d;
   logic                  par_err_q, par_err_d;
   logic                  dv_q, dv_d;
   logic                  pe_q, pe_d;
   logic                  se_q, se_d;

   logic                  last_edge;
   logic                  bit_val;

   // Two-flop synchronizer; everything downstream uses rx_s only.
   assign rx_s = sync_q[1];

   uart_rx_sampler u_sampler (
      .CLK         (CLK),
      .Reset       (Reset),
      .en_i        (state_q != IDLE),
      .prescale_i  (presc_q),
      .rx_i        (rx_s),
      .last_edge_o (last_edge),
      .bit_o       (bit_val)
   );

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      data_d     = data_q;
      presc_d    = presc_q;
      par_en_d   = par_en_q;
      par_type_d = par_type_q;
      par_err_d  = par_err_q;
      dv_d       = 1'b0;
      pe_d       = 1'b0;
      se_d       = 1'b0;

      case (state_q)
         IDLE: begin
            // Frame configuration is frozen from the cycle we leave IDLE.
            presc_d    = Prescale;
            par_en_d   = Parity_EN;
            par_type_d = Parity_type;
            bit_cnt_d  = '0;
            par_err_d  = 1'b0;
            if (!rx_s) state_d = START;
         end
         START: begin
            if (last_edge) begin
               bit_cnt_d = '0;
               par_err_d = 1'b0;
               state_d   = bit_val ? IDLE : DATA;
            end
         end
         DATA: begin
            if (last_edge) begin
               shift_d = {bit_val, shift_q[width-1:1]};
               if (bit_cnt_q == BCNT_W'(width - 1)) begin
                  state_d = par_en_q ? PARITY : STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BCNT_W'(1);
               end
            end
         end
         PARITY: begin
            if (last_edge) begin
               par_err_d = (bit_val != expected_parity(^shift_q, par_type_q));
               state_d   = STOP;
            end
         end
         STOP: begin
            if (last_edge) begin
               se_d = ~bit_val;
               pe_d = par_err_q;
               dv_d = bit_val & ~par_err_q;
               if (bit_val && !par_err_q) data_d = shift_q;
               // A low line right here is the start bit of the next frame.
               state_d = rx_s ? IDLE : START;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_q    <= IDLE;
         sync_q     <= 2'b11;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         data_q     <= '0;
         presc_q    <= PRESCALE_16;
         par_en_q   <= 1'b0;
         par_type_q <= PARITY_EVEN;
         par_err_q  <= 1'b0;
         dv_q       <= 1'b0;
         pe_q       <= 1'b0;
         se_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_q     <= {sync_q[0], Rx_in};
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         presc_q    <= presc_d;
         par_en_q   <= par_en_d;
         par_type_q <= par_type_d;
         par_err_q  <= par_err_d;
         dv_q       <= dv_d;
         pe_q       <= pe_d;
         se_q       <= se_d;
      end
   end

   assign Data_out     = data_q;
   assign Data_valid   = dv_q;
   assign Parity_error = pe_q;
   assign Stop_error   = se_q;

endmodule
